// File: rtl/frame_header_parser.sv
// -----------------------------------------------------------------------------
// frame_header_parser
//
// Byte-serial receive header parser sitting in front of the payload/CRC stage.
// It checks the preamble, the SFD, the destination address (station or
// broadcast) and the length field, and it captures the source address. On a
// good header it raises payload_enable. That level enables the downstream
// payload/CRC stage and stays high until the stage reports packet_done.
//
// Ports
//   clock             in   1  system clock, rising edge
//   reset_n           in   1  asynchronous active-low reset
//   data_in           in   8  received byte
//   data_valid        in   1  data_in carries a new byte this cycle
//   packet_done       in   1  end of payload/CRC from the downstream stage
//   payload_enable    out  1  level enable for the payload/CRC stage
//   header_error      out  1  one-cycle pulse on any header violation
//   dest_is_broadcast out  1  destination was all-ones (valid with payload_enable)
//   src_addr          out 48  captured source address (valid with payload_enable)
//   length_field      out 16  captured length field (valid with payload_enable)
//   state_dbg         out  3  current parser state, for observation only
//
// Handshake: a byte is taken on every rising edge where data_valid is high.
// There is no back-pressure. In PAYLOAD and ERROR the byte stream is ignored.
// -----------------------------------------------------------------------------
module frame_header_parser #(
    parameter logic [47:0] MY_ADDR        = 48'h0000_0000_0001,
    parameter int          PREAMBLE_BYTES = 7,
    parameter logic [15:0] EXP_LENGTH     = 16'd46
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        packet_done,
    output logic        payload_enable,
    output logic        header_error,
    output logic        dest_is_broadcast,
    output logic [47:0] src_addr,
    output logic [15:0] length_field,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DEST     = 3'd3,
        ST_SRC      = 3'd4,
        ST_LEN      = 3'd5,
        ST_PAYLOAD  = 3'd6,
        ST_ERROR    = 3'd7
    } state_t;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    // The byte that takes the count to PREAMBLE_BYTES arrives while the
    // counter still reads one less.
    localparam logic [2:0]  PRE_LAST  = 3'(PREAMBLE_BYTES - 1);
    localparam logic [2:0]  ADDR_LAST = 3'd5;
    localparam logic [2:0]  LEN_LAST  = 3'd1;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [47:0] dest_q, dest_d;
    logic [47:0] src_q, src_d;
    logic [15:0] len_q, len_d;
    logic        bcast_q, bcast_d;
    logic        pen_q, pen_d;
    logic        herr_q, herr_d;

    // Values as they would stand once the current byte is shifted in. The
    // final-byte decisions are made on these values.
    logic [47:0] dest_full;
    logic [15:0] len_full;

    assign dest_full = {dest_q[39:0], data_in};
    assign len_full  = {len_q[7:0], data_in};

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Any other byte is line noise between frames and is not an error.
                if (data_valid && data_in == PRE_BYTE) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (data_valid) begin
                    if (data_in != PRE_BYTE) begin
                        state_d = ST_ERROR;
                    end else if (cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                    end
                end
            end
            ST_SFD: begin
                // An extra preamble byte lands here and is rejected.
                if (data_valid) begin
                    state_d = (data_in == SFD_BYTE) ? ST_DEST : ST_ERROR;
                end
            end
            ST_DEST: begin
                if (data_valid && cnt_q == ADDR_LAST) begin
                    if (dest_full == MY_ADDR || dest_full == BCAST) begin
                        state_d = ST_SRC;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_SRC: begin
                if (data_valid && cnt_q == ADDR_LAST) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (data_valid && cnt_q == LEN_LAST) begin
                    state_d = (len_full == EXP_LENGTH) ? ST_PAYLOAD : ST_ERROR;
                end
            end
            ST_PAYLOAD: begin
                // packet_done takes priority over any byte in the same cycle.
                if (packet_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------- outputs and datapath
    always_comb begin
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        src_d   = src_q;
        len_d   = len_q;
        bcast_d = bcast_q;

        // The counter restarts on every state entry. IDLE->PREAMBLE already
        // consumed the first preamble byte, so that entry starts at 1.
        if (state_d != state_q) begin
            cnt_d = (state_d == ST_PREAMBLE) ? 3'd1 : 3'd0;
        end else if (data_valid &&
                     (state_q == ST_PREAMBLE || state_q == ST_DEST ||
                      state_q == ST_SRC      || state_q == ST_LEN)) begin
            cnt_d = cnt_q + 3'd1;
        end

        if (data_valid) begin
            case (state_q)
                ST_DEST: dest_d = dest_full;
                ST_SRC:  src_d  = {src_q[39:0], data_in};
                ST_LEN:  len_d  = len_full;
                default: ;
            endcase
        end

        if (state_q == ST_DEST && state_d == ST_SRC) begin
            bcast_d = (dest_full == BCAST);
        end

        // The captured fields only mean something while payload_enable is
        // high. Wipe them whenever the parser returns to IDLE.
        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            src_d   = '0;
            len_d   = '0;
            bcast_d = 1'b0;
        end

        pen_d  = (state_d == ST_PAYLOAD);
        herr_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            dest_q  <= '0;
            src_q   <= '0;
            len_q   <= '0;
            bcast_q <= 1'b0;
            pen_q   <= 1'b0;
            herr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            len_q   <= len_d;
            bcast_q <= bcast_d;
            pen_q   <= pen_d;
            herr_q  <= herr_d;
        end
    end

    assign payload_enable    = pen_q;
    assign header_error      = herr_q;
    assign dest_is_broadcast = bcast_q;
    assign src_addr          = src_q;
    assign length_field      = len_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_frame_header_parser.sv
// -----------------------------------------------------------------------------
// tb_frame_header_parser
//
// Directed bench for frame_header_parser. The byte stream is driven one byte
// per clock. Outputs are sampled 1 ns after the rising edge that consumed the
// last byte. Every expected value below was worked out by hand from the frame
// layout.
// -----------------------------------------------------------------------------
module tb_frame_header_parser;

    localparam logic [47:0] MY_ADDR = 48'h0000_0000_0001;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_A   = 48'h0211_2233_4455;
    localparam logic [47:0] SRC_B   = 48'h0A0B_0C0D_0E0F;
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_DEST  = 3'd3;
    localparam logic [2:0]  S_SRC   = 3'd4;

    logic        clock;
    logic        reset_n;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        packet_done;
    logic        payload_enable;
    logic        header_error;
    logic        dest_is_broadcast;
    logic [47:0] src_addr;
    logic [15:0] length_field;
    logic [2:0]  state_dbg;

    int errors;
    int checks;

    frame_header_parser dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .packet_done       (packet_done),
        .payload_enable    (payload_enable),
        .header_error      (header_error),
        .dest_is_broadcast (dest_is_broadcast),
        .src_addr          (src_addr),
        .length_field      (length_field),
        .state_dbg         (state_dbg)
    );

    // ------------------------------------------------------------ clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------- checker
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic idle_cycle();
        data_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // One byte, consumed on the next rising edge, then `gap` empty cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        repeat (gap) idle_cycle();
    endtask

    task automatic send_pre_sfd(input int gap);
        for (int i = 0; i < 7; i++) send_byte(8'h55, gap);
        send_byte(8'hD5, gap);
    endtask

    task automatic send_addr(input logic [47:0] a, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_byte(a[47 - 8*i -: 8], gap);
    endtask

    task automatic send_len(input logic [15:0] l, input int gap);
        send_byte(l[15:8], gap);
        send_byte(l[7:0], gap);
    endtask

    task automatic pulse_done();
        packet_done = 1'b1;
        @(posedge clock);
        #1;
        packet_done = 1'b0;
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        packet_done = 1'b0;
        #1;
        chk("rst_pen",   64'(payload_enable), 64'd0);
        chk("rst_herr",  64'(header_error), 64'd0);
        chk("rst_bcast", 64'(dest_is_broadcast), 64'd0);
        chk("rst_src",   64'(src_addr), 64'd0);
        chk("rst_len",   64'(length_field), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'(S_IDLE));
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle_cycle();

        // Good unicast frame.
        send_pre_sfd(0);
        send_addr(MY_ADDR, 0, 5, 0);
        send_addr(SRC_A, 0, 5, 0);
        send_byte(8'h00, 0);
        chk("uni_pen_early", 64'(payload_enable), 64'd0);
        send_byte(8'h2E, 0);
        chk("uni_pen",   64'(payload_enable), 64'd1);
        chk("uni_src",   64'(src_addr), 64'(SRC_A));
        chk("uni_len",   64'(length_field), 64'h002E);
        chk("uni_bcast", 64'(dest_is_broadcast), 64'd0);
        chk("uni_herr",  64'(header_error), 64'd0);
        // Payload bytes are not header bytes, even when one of them is 0x55.
        for (int i = 0; i < 51; i++) send_byte(8'(i * 5), 0);
        chk("uni_pen_hold", 64'(payload_enable), 64'd1);
        chk("uni_src_hold", 64'(src_addr), 64'(SRC_A));
        pulse_done();
        chk("uni_pen_drop", 64'(payload_enable), 64'd0);
        chk("uni_src_clr",  64'(src_addr), 64'd0);
        chk("uni_len_clr",  64'(length_field), 64'd0);
        chk("uni_state",    64'(state_dbg), 64'(S_IDLE));

        // Broadcast frame.
        send_pre_sfd(0);
        send_addr(BCAST, 0, 5, 0);
        send_addr(SRC_A, 0, 5, 0);
        send_len(16'h002E, 0);
        chk("bc_pen",   64'(payload_enable), 64'd1);
        chk("bc_bcast", 64'(dest_is_broadcast), 64'd1);
        pulse_done();
        chk("bc_bcast_clr", 64'(dest_is_broadcast), 64'd0);

        // Foreign destination address.
        send_pre_sfd(0);
        send_addr(48'h0000_0000_0002, 0, 5, 0);
        chk("dst_herr", 64'(header_error), 64'd1);
        chk("dst_pen",  64'(payload_enable), 64'd0);
        idle_cycle();
        chk("dst_herr_end", 64'(header_error), 64'd0);

        // Bad preamble, then a good frame.
        send_byte(8'h55, 0);
        send_byte(8'h55, 0);
        chk("pre_no_err", 64'(header_error), 64'd0);
        send_byte(8'hAA, 0);
        chk("pre_herr", 64'(header_error), 64'd1);
        idle_cycle();
        chk("pre_herr_end", 64'(header_error), 64'd0);
        chk("pre_state",    64'(state_dbg), 64'(S_IDLE));
        send_pre_sfd(0);
        send_addr(MY_ADDR, 0, 5, 0);
        send_addr(SRC_A, 0, 5, 0);
        send_len(16'h002E, 0);
        chk("pre_recover_pen", 64'(payload_enable), 64'd1);
        pulse_done();

        // Eight preamble bytes: the 8th lands on the SFD slot and is rejected.
        for (int i = 0; i < 7; i++) send_byte(8'h55, 0);
        chk("long_pre_ok", 64'(header_error), 64'd0);
        send_byte(8'h55, 0);
        chk("long_pre_herr", 64'(header_error), 64'd1);
        send_byte(8'hD5, 0);
        chk("long_pre_herr_end", 64'(header_error), 64'd0);
        chk("long_pre_state",    64'(state_dbg), 64'(S_IDLE));

        // Length mismatch.
        send_pre_sfd(0);
        send_addr(MY_ADDR, 0, 5, 0);
        send_addr(SRC_A, 0, 5, 0);
        send_len(16'h05DC, 0);
        chk("len_herr", 64'(header_error), 64'd1);
        chk("len_pen",  64'(payload_enable), 64'd0);
        idle_cycle();
        chk("len_pen_after", 64'(payload_enable), 64'd0);

        // Good frame with three empty cycles after every header byte.
        send_pre_sfd(3);
        send_addr(MY_ADDR, 0, 5, 3);
        send_addr(SRC_A, 0, 5, 3);
        send_byte(8'h00, 3);
        chk("gap_pen_early", 64'(payload_enable), 64'd0);
        send_byte(8'h2E, 0);
        chk("gap_pen",  64'(payload_enable), 64'd1);
        chk("gap_src",  64'(src_addr), 64'(SRC_A));
        chk("gap_len",  64'(length_field), 64'h002E);
        chk("gap_herr", 64'(header_error), 64'd0);
        pulse_done();

        // Asynchronous reset after the third source byte.
        send_pre_sfd(0);
        send_addr(MY_ADDR, 0, 5, 0);
        send_addr(SRC_A, 0, 2, 0);
        chk("mid_state", 64'(state_dbg), 64'(S_SRC));
        chk("mid_src",   64'(src_addr), 64'h0000_0002_1122);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_src",   64'(src_addr), 64'd0);
        chk("mid_rst_state", 64'(state_dbg), 64'(S_IDLE));
        chk("mid_rst_pen",   64'(payload_enable), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        send_pre_sfd(0);
        send_addr(MY_ADDR, 0, 5, 0);
        send_addr(SRC_B, 0, 5, 0);
        send_len(16'h002E, 0);
        chk("post_rst_pen", 64'(payload_enable), 64'd1);
        chk("post_rst_src", 64'(src_addr), 64'(SRC_B));
        pulse_done();

        // packet_done outside PAYLOAD has no effect.
        pulse_done();
        chk("done_idle_state", 64'(state_dbg), 64'(S_IDLE));
        chk("done_idle_herr",  64'(header_error), 64'd0);
        send_pre_sfd(0);
        send_addr(MY_ADDR, 0, 1, 0);
        pulse_done();
        chk("done_dest_state", 64'(state_dbg), 64'(S_DEST));
        send_addr(MY_ADDR, 2, 5, 0);
        send_addr(SRC_A, 0, 5, 0);
        send_len(16'h002E, 0);
        chk("done_dest_pen", 64'(payload_enable), 64'd1);

        // packet_done together with a byte in PAYLOAD: done wins.
        data_in     = 8'hAB;
        data_valid  = 1'b1;
        packet_done = 1'b1;
        @(posedge clock);
        #1;
        data_valid  = 1'b0;
        packet_done = 1'b0;
        chk("coinc_pen",   64'(payload_enable), 64'd0);
        chk("coinc_state", 64'(state_dbg), 64'(S_IDLE));
        chk("coinc_herr",  64'(header_error), 64'd0);
        idle_cycle();
        chk("coinc_herr2", 64'(header_error), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
